seq_divider: RTL and testbench

- Iterative unsigned N-bit restoring divider; the inverse operation of the team's N-bit multiplier datapath.
- Produces quotient and remainder one bit per clock under a start/done handshake.
- Intended as the shared divide unit beside the multiplier. Its bench can cross-check it against the multiplier: dividend = quotient*divisor + remainder.

---
 rtl/seq_divider.sv | 162 ++++++++++++++++
 tb/tb_seq_divider.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Iterative unsigned N-bit restoring divider. One quotient bit is produced
//   per clock while in RUN; results are registered and presented with a
//   one-cycle done pulse. A zero divisor short-circuits straight to DONE with
//   quotient = all ones, remainder = dividend and div_by_zero set.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only in IDLE
//   dividend     N-bit unsigned dividend, captured on accept
//   divisor      N-bit unsigned divisor, captured on accept
//   busy         high exactly while iterating (RUN)
//   done         one-cycle pulse, results valid while high
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  registered flag, set when the captured divisor was zero
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;

    // Working registers: dvd_q shifts dividend bits out of its MSB while
    // quotient bits enter at its LSB, so after N steps it holds the quotient.
    logic [N-1:0]   dvd_q;
    logic [N-1:0]   dvs_q;
    logic [N-1:0]   rem_q;
    logic [CW-1:0]  cnt_q;

    // Result registers, only written on the DONE entry edge.
    logic [N-1:0]   quot_q;
    logic [N-1:0]   rem_out_q;
    logic           dbz_q;

    // One restoring step.
    logic [N:0]     trial;
    logic [N-1:0]   shifted;
    logic           qbit;
    logic [N-1:0]   rem_step;
    logic [N-1:0]   quo_step;
    logic           last_iter;
    logic           accept;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath step
    // -------------------------------------------------------------------------
    always_comb begin
        accept    = (state_q == IDLE) && start;
        last_iter = (cnt_q == CW'(1));
        // Because rem_q < dvs_q, the shifted value is < 2*dvs_q, so the
        // (N+1)-bit difference has its MSB set exactly when it is negative.
        trial     = {rem_q, dvd_q[N-1]} - {1'b0, dvs_q};
        shifted   = {rem_q[N-2:0], dvd_q[N-1]};
        qbit      = ~trial[N];
        rem_step  = qbit ? trial[N-1:0] : shifted;
        quo_step  = {dvd_q[N-2:0], qbit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_out_q <= '0;
            dbz_q     <= 1'b0;
        end else if (accept) begin
            if (divisor == '0) begin
                quot_q    <= '1;
                rem_out_q <= dividend;
                dbz_q     <= 1'b1;
            end else begin
                dvd_q <= dividend;
                dvs_q <= divisor;
                rem_q <= '0;
                cnt_q <= CW'(N);
                dbz_q <= 1'b0;
            end
        end else if (state_q == RUN) begin
            dvd_q <= quo_step;
            rem_q <= rem_step;
            cnt_q <= cnt_q - CW'(1);
            if (last_iter) begin
                quot_q    <= quo_step;
                rem_out_q <= rem_step;
            end
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_out_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Self-checking bench for seq_divider (N = 16): a table of directed vectors
//   with hand-computed results, hand-written sequences for ignored start,
//   mid-operation reset, start held through DONE and output stability, then
//   a random sweep checked against the division invariant.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int N = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         z;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for done. lat counts clock
    // edges from the accept edge to the edge that raised done.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [N-1:0] q, output logic [N-1:0] r,
                          output logic z, output int lat, output int bc,
                          output logic done_after, output bit timeout);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        lat     = 0;
        bc      = 0;
        timeout = 1'b0;
        while (done !== 1'b1) begin
            if (busy === 1'b1) bc++;
            if (lat >= 100) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
        @(negedge clk);
        done_after = done;
    endtask

    vec_t         vecs[13];
    logic [N-1:0] q, r;
    logic         z, da;
    int           lat, bc;
    bit           to;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        vecs[0]  = '{16'd100,   16'd7,      16'd14,     16'd2,      1'b0};
        vecs[1]  = '{16'hFFFF,  16'd1,      16'hFFFF,   16'd0,      1'b0};
        vecs[2]  = '{16'd3,     16'd10,     16'd0,      16'd3,      1'b0};
        vecs[3]  = '{16'd5,     16'd0,      16'hFFFF,   16'd5,      1'b1};
        vecs[4]  = '{16'd0,     16'd9,      16'd0,      16'd0,      1'b0};
        vecs[5]  = '{16'd1000,  16'd3,      16'd333,    16'd1,      1'b0};
        vecs[6]  = '{16'd60000, 16'd7,      16'd8571,   16'd3,      1'b0};
        vecs[7]  = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,      1'b0};
        vecs[8]  = '{16'hFFFE,  16'hFFFF,   16'd0,      16'hFFFE,   1'b0};
        vecs[9]  = '{16'hFFFF,  16'd2,      16'h7FFF,   16'd1,      1'b0};
        vecs[10] = '{16'd12345, 16'd123,    16'd100,    16'd45,     1'b0};
        vecs[11] = '{16'd0,     16'd0,      16'hFFFF,   16'd0,      1'b1};
        vecs[12] = '{16'd40000, 16'd200,    16'd200,    16'd0,      1'b0};

        // Reset state
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].a, vecs[i].b, q, r, z, lat, bc, da, to);
            check($sformatf("vec%0d timeout", i), 32'(to), 32'd0);
            check($sformatf("vec%0d quotient", i), 32'(q), 32'(vecs[i].q));
            check($sformatf("vec%0d remainder", i), 32'(r), 32'(vecs[i].r));
            check($sformatf("vec%0d dbz", i), 32'(z), 32'(vecs[i].z));
            // A zero divisor reaches DONE on the accept edge itself.
            check($sformatf("vec%0d latency", i), 32'(lat), vecs[i].z ? 32'd0 : 32'(N));
            check($sformatf("vec%0d busy cycles", i), 32'(bc), vecs[i].z ? 32'd0 : 32'(N));
            check($sformatf("vec%0d done one cycle", i), 32'(da), 32'd0);
        end

        // Start pulse during RUN is ignored; operand changes after capture too
        begin
            int ndone = 0;
            int done_at = -1;
            logic [N-1:0] dq = '0, dr = '0;
            @(negedge clk);
            dividend = 16'd1000;
            divisor  = 16'd3;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < N + 8; c++) begin
                if (c == 3) begin
                    dividend = 16'd50;
                    divisor  = 16'd5;
                    start    = 1'b1;
                end else if (c == 4) begin
                    start = 1'b0;
                end
                if (done === 1'b1) begin
                    ndone++;
                    done_at = c;
                    dq = quotient;
                    dr = remainder;
                end
                @(negedge clk);
            end
            check("ignored start done count", 32'(ndone), 32'd1);
            check("ignored start latency", 32'(done_at), 32'(N));
            check("ignored start quotient", 32'(dq), 32'd333);
            check("ignored start remainder", 32'(dr), 32'd1);
            check("ignored start not queued", 32'(busy), 32'd0);
        end

        // Reset in the middle of RUN
        begin
            int nd = 0, nb = 0;
            @(negedge clk);
            dividend = 16'd60000;
            divisor  = 16'd7;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (8) @(negedge clk);
            check("pre-abort busy", 32'(busy), 32'd1);
            #2 rst_n = 1'b0;
            #1;
            check("abort busy", 32'(busy), 32'd0);
            check("abort done", 32'(done), 32'd0);
            check("abort quotient", 32'(quotient), 32'd0);
            check("abort remainder", 32'(remainder), 32'd0);
            check("abort dbz", 32'(div_by_zero), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < N + 4; c++) begin
                @(negedge clk);
                if (done === 1'b1) nd++;
                if (busy === 1'b1) nb++;
            end
            check("abort no done", 32'(nd), 32'd0);
            check("abort no busy", 32'(nb), 32'd0);
            run_op(16'd60000, 16'd7, q, r, z, lat, bc, da, to);
            check("post-abort timeout", 32'(to), 32'd0);
            check("post-abort quotient", 32'(q), 32'd8571);
            check("post-abort remainder", 32'(r), 32'd3);
        end

        // Start held high through DONE is accepted on the first IDLE cycle
        begin
            int w = 0;
            @(negedge clk);
            dividend = 16'd100;
            divisor  = 16'd7;
            start    = 1'b1;
            while (done !== 1'b1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            check("held start first done", 32'(done), 32'd1);
            @(negedge clk);
            check("held start idle gap busy", 32'(busy), 32'd0);
            @(negedge clk);
            check("held start re-accepted", 32'(busy), 32'd1);
            start = 1'b0;
            w = 0;
            while (done !== 1'b1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            check("held start second done", 32'(done), 32'd1);
            check("held start quotient", 32'(quotient), 32'd14);
            check("held start remainder", 32'(remainder), 32'd2);
        end

        // Outputs hold through IDLE regardless of operand inputs
        @(negedge clk);
        dividend = 16'hFFFF;
        divisor  = 16'd0;
        repeat (5) @(negedge clk);
        check("hold quotient", 32'(quotient), 32'd14);
        check("hold remainder", 32'(remainder), 32'd2);
        check("hold dbz", 32'(div_by_zero), 32'd0);

        // Random sweep against the invariant
        begin
            int mism = 0;
            int nops = 2000;
            for (int i = 0; i < nops; i++) begin
                logic [N-1:0] a, b;
                bit bad;
                a = N'($urandom);
                case ($urandom_range(0, 7))
                    0:       b = '0;
                    1:       b = N'($urandom_range(1, 15));
                    default: b = N'($urandom);
                endcase
                run_op(a, b, q, r, z, lat, bc, da, to);
                bad = to;
                if (b == '0) begin
                    if (q !== '1 || r !== a || z !== 1'b1) bad = 1'b1;
                end else begin
                    if (z !== 1'b0 || r >= b || (32'(q) * 32'(b) + 32'(r)) != 32'(a)) bad = 1'b1;
                end
                checks++;
                if (bad) begin
                    failures++;
                    mism++;
                    if (mism <= 10)
                        $display("FAIL random a=%0d b=%0d: got q=%0d r=%0d dbz=%0d", a, b, q, r, z);
                end
            end
            $display("random ops=%0d mismatches=%0d", nops, mism);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
